// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray/binary pointer conversions and parameter legality helpers for the FIFO pointer logic.
package fifo_pkg;

    localparam int MAX_PW = 13;

    function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Upper unused bits must be zero; then any pointer width up to MAX_PW converts correctly.
    function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] g);
        logic [MAX_PW-1:0] b;
        b[MAX_PW-1] = g[MAX_PW-1];
        for (int i = MAX_PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic bit awidth_ok(input int aw);
        return aw >= 2 && aw <= 12;
    endfunction

    function automatic bit sync_ok(input int st);
        return st >= 2 && st <= 4;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// gray_sync: multi-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
module gray_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wr_side_ctrl.sv
// wr_side_ctrl: write-domain half of an async FIFO; owns the write pointer and derives
// full, almost-full, fill level and sticky overflow against a synchronized read pointer.
module wr_side_ctrl
    import fifo_pkg::*;
#(
    parameter int AWIDTH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LVL   = 2**AWIDTH - 2
) (
    input  logic              wr_clk_i,
    input  logic              aclr_i,
    input  logic              wr_req_i,
    input  logic [AWIDTH:0]   rd_pntr_gray_i,
    input  logic              wr_ovf_clr_i,
    output logic              wr_en_o,
    output logic [AWIDTH-1:0] wr_addr_o,
    output logic [AWIDTH:0]   wr_pntr_gray_o,
    output logic              wr_full_o,
    output logic              wr_afull_o,
    output logic [AWIDTH:0]   wr_usedw_o,
    output logic              wr_ovf_o
);

    if (!awidth_ok(AWIDTH) || !sync_ok(SYNC_STAGES) || AFULL_LVL < 1 || AFULL_LVL > 2**AWIDTH) begin : g_bad_param
        $error("wr_side_ctrl: illegal AWIDTH, SYNC_STAGES or AFULL_LVL");
    end

    localparam logic [AWIDTH:0] DEPTH = (AWIDTH+1)'(2**AWIDTH);
    localparam logic [AWIDTH:0] AFULL = (AWIDTH+1)'(AFULL_LVL);

    logic [AWIDTH:0]   rd_gray_s, rd_bin_s;
    logic [MAX_PW-1:0] rd_bin_w, wr_gray_w;
    logic [AWIDTH:0]   wr_bin_q, wr_bin_d, gray_q, gray_d, used_q, used_d;
    logic              full_q, full_d, afull_q, afull_d, ovf_q, ovf_d;

    gray_sync #(.WIDTH(AWIDTH+1), .STAGES(SYNC_STAGES)) u_rd_sync (
        .clk    (wr_clk_i),
        .aclr_n (aclr_i),
        .d_i    (rd_pntr_gray_i),
        .q_o    (rd_gray_s)
    );

    assign rd_bin_w  = gray2bin(MAX_PW'(rd_gray_s));
    assign rd_bin_s  = rd_bin_w[AWIDTH:0];
    assign wr_gray_w = bin2gray(MAX_PW'(wr_bin_d));
    assign wr_en_o   = wr_req_i & ~full_q;

    always_comb begin
        wr_bin_d = wr_bin_q + (AWIDTH+1)'(wr_en_o);
        gray_d   = wr_gray_w[AWIDTH:0];
        used_d   = wr_bin_d - rd_bin_s;
        full_d   = used_d == DEPTH;
        afull_d  = used_d >= AFULL;
        ovf_d    = (wr_req_i & full_q) | (ovf_q & ~wr_ovf_clr_i);
    end

    always_ff @(posedge wr_clk_i or negedge aclr_i) begin
        if (!aclr_i) begin
            wr_bin_q <= '0;
            gray_q   <= '0;
            used_q   <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_bin_q <= wr_bin_d;
            gray_q   <= gray_d;
            used_q   <= used_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wr_addr_o      = wr_bin_q[AWIDTH-1:0];
    assign wr_pntr_gray_o = gray_q;
    assign wr_usedw_o     = used_q;
    assign wr_full_o      = full_q;
    assign wr_afull_o     = afull_q;
    assign wr_ovf_o       = ovf_q;

endmodule

// File: tb/tb_wr_side_ctrl.sv
// tb_wr_side_ctrl: directed vectors with hand-computed expectations for wr_side_ctrl (AWIDTH=4).
module tb_wr_side_ctrl;

    logic       wr_clk_i = 1'b0;
    logic       aclr_i = 1'b0;
    logic       wr_req_i = 1'b0;
    logic [4:0] rd_pntr_gray_i = '0;
    logic       wr_ovf_clr_i = 1'b0;
    logic       wr_en_o;
    logic [3:0] wr_addr_o;
    logic [4:0] wr_pntr_gray_o;
    logic       wr_full_o;
    logic       wr_afull_o;
    logic [4:0] wr_usedw_o;
    logic       wr_ovf_o;

    int vectors = 0;
    int miscompares = 0;

    wr_side_ctrl #(.AWIDTH(4), .SYNC_STAGES(2), .AFULL_LVL(14)) dut (
        .wr_clk_i       (wr_clk_i),
        .aclr_i         (aclr_i),
        .wr_req_i       (wr_req_i),
        .rd_pntr_gray_i (rd_pntr_gray_i),
        .wr_ovf_clr_i   (wr_ovf_clr_i),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_pntr_gray_o (wr_pntr_gray_o),
        .wr_full_o      (wr_full_o),
        .wr_afull_o     (wr_afull_o),
        .wr_usedw_o     (wr_usedw_o),
        .wr_ovf_o       (wr_ovf_o)
    );

    always #5 wr_clk_i = ~wr_clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] g(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic step;
        @(posedge wr_clk_i);
        @(negedge wr_clk_i);
    endtask

    int wr_m, rd_m, m1, m2, acc, exp_used;
    logic [4:0] prev_gray;
    logic [3:0] prev_addr;

    initial begin
        // reset state, with a request pending
        wr_req_i = 1'b1;
        #12;
        chk("rst_usedw", wr_usedw_o, 0);
        chk("rst_full", wr_full_o, 0);
        chk("rst_afull", wr_afull_o, 0);
        chk("rst_ovf", wr_ovf_o, 0);
        chk("rst_gray", wr_pntr_gray_o, 0);
        chk("rst_addr", wr_addr_o, 0);
        chk("rst_en_eq_req", wr_en_o, 1);
        wr_req_i = 1'b0;
        @(negedge wr_clk_i);
        aclr_i = 1'b1;

        // fill sixteen words
        for (int i = 0; i < 16; i++) begin
            wr_req_i = 1'b1;
            #1;
            chk("fill_en", wr_en_o, 1);
            chk("fill_addr", wr_addr_o, i);
            step();
            chk("fill_usedw", wr_usedw_o, i + 1);
            chk("fill_afull", wr_afull_o, (i + 1 >= 14) ? 1 : 0);
            chk("fill_full", wr_full_o, (i + 1 == 16) ? 1 : 0);
            chk("fill_gray", wr_pntr_gray_o, g(i + 1));
        end

        // requests while full
        for (int i = 0; i < 3; i++) begin
            wr_req_i = 1'b1;
            #1;
            chk("ovf_en", wr_en_o, 0);
            step();
            chk("ovf_flag", wr_ovf_o, 1);
            chk("ovf_addr", wr_addr_o, 0);
            chk("ovf_gray", wr_pntr_gray_o, g(16));
            chk("ovf_usedw", wr_usedw_o, 16);
        end
        wr_req_i = 1'b0;
        wr_ovf_clr_i = 1'b1;
        step();
        chk("ovf_clr", wr_ovf_o, 0);

        // clear and set together: set wins
        wr_ovf_clr_i = 1'b0;
        wr_req_i = 1'b1;
        step();
        chk("ovf_set_again", wr_ovf_o, 1);
        wr_ovf_clr_i = 1'b1;
        step();
        chk("ovf_set_wins", wr_ovf_o, 1);
        wr_req_i = 1'b0;
        step();
        chk("ovf_clr2", wr_ovf_o, 0);
        wr_ovf_clr_i = 1'b0;

        // read of four words becomes visible after three edges
        rd_pntr_gray_i = g(4);
        step();
        chk("rd_lag1_full", wr_full_o, 1);
        chk("rd_lag1_usedw", wr_usedw_o, 16);
        step();
        chk("rd_lag2_usedw", wr_usedw_o, 16);
        step();
        chk("rd_vis_usedw", wr_usedw_o, 12);
        chk("rd_vis_full", wr_full_o, 0);
        chk("rd_vis_afull", wr_afull_o, 0);
        wr_req_i = 1'b1;
        #1;
        chk("wrap_en", wr_en_o, 1);
        chk("wrap_addr", wr_addr_o, 0);
        step();
        chk("wrap_usedw", wr_usedw_o, 13);
        chk("wrap_gray", wr_pntr_gray_o, g(17));
        wr_req_i = 1'b0;

        // free-running read chasing the writer for 40 accepted words
        wr_m = 17; rd_m = 4; m1 = 4; m2 = 4; acc = 0;
        for (int cyc = 0; cyc < 200 && acc < 40; cyc++) begin
            prev_gray = wr_pntr_gray_o;
            prev_addr = wr_addr_o;
            rd_pntr_gray_i = g(rd_m);
            wr_req_i = (((wr_m - rd_m) & 31) < 8) ? 1'b1 : 1'b0;
            #1;
            chk("run_en", wr_en_o, wr_req_i);
            @(posedge wr_clk_i);
            if (wr_req_i) wr_m = (wr_m + 1) & 31;
            exp_used = (wr_m - m2) & 31;
            m2 = m1;
            m1 = rd_m;
            @(negedge wr_clk_i);
            chk("run_usedw", wr_usedw_o, exp_used);
            chk("run_gray", wr_pntr_gray_o, g(wr_m));
            chk("run_addr", wr_addr_o, wr_m & 15);
            chk("run_full_inv", wr_full_o, (wr_usedw_o == 16) ? 1 : 0);
            if (wr_req_i) begin
                acc++;
                chk("run_gray_1bit", $countones(prev_gray ^ wr_pntr_gray_o), 1);
                if (prev_addr == 4'd15) chk("run_msb_toggle", wr_pntr_gray_o[4] ^ prev_gray[4], 1);
            end
            if (rd_m != wr_m) rd_m = (rd_m + 1) & 31;
        end
        chk("run_accepts", acc, 40);

        // drain, then write nine words and reset mid-stream
        wr_req_i = 1'b0;
        rd_pntr_gray_i = g(wr_m);
        repeat (4) step();
        chk("drain_usedw", wr_usedw_o, 0);
        wr_req_i = 1'b1;
        repeat (9) step();
        wr_req_i = 1'b0;
        chk("pre_rst_usedw", wr_usedw_o, 9);
        #2 aclr_i = 1'b0;
        #1;
        chk("arst_usedw", wr_usedw_o, 0);
        chk("arst_full", wr_full_o, 0);
        chk("arst_afull", wr_afull_o, 0);
        chk("arst_ovf", wr_ovf_o, 0);
        chk("arst_gray", wr_pntr_gray_o, 0);
        chk("arst_addr", wr_addr_o, 0);
        wr_req_i = 1'b1;
        #1;
        chk("arst_en_eq_req", wr_en_o, 1);
        wr_req_i = 1'b0;
        rd_pntr_gray_i = '0;
        @(negedge wr_clk_i);
        aclr_i = 1'b1;
        wr_req_i = 1'b1;
        #1;
        chk("post_rst_addr", wr_addr_o, 0);
        chk("post_rst_en", wr_en_o, 1);
        step();
        chk("post_rst_usedw", wr_usedw_o, 1);
        chk("post_rst_gray", wr_pntr_gray_o, 1);
        wr_req_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
